logicnet_input_packer: RTL and testbench
========================================

Name: logicnet_input_packer

Overview:
- Front end of the LogicNet inference datapath. Sits between the raw-feature stream and the layer0 LUT neuron array.
- Accepts one signed raw feature per beat over a valid/ready stream and quantizes each feature to an ACT_W-bit code using per-feature programmable thresholds.
- Packs NUM_FEATURES codes into one activation vector and presents it to layer0 with a valid/ready handshake.
- It is the producer, or encoder, side of the quantized-activation interface that the layer0 neurons decode.

Parameters:
- NUM_FEATURES, 16: number of features per input vector.
- FEAT_W, 16: width of the raw feature, two's complement.
- ACT_W, 2: code width. Each feature has 2^ACT_W-1 thresholds.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  raw feature beat valid.
- s_ready  out  1  packer can accept a beat.
- s_data  in  FEAT_W  raw signed feature.
- s_last  in  1  marks the final feature of a vector.
- m_valid  out  1  packed vector valid.
- m_ready  in  1  layer0 consumer accepts the vector.
- m_data  out  NUM_FEATURES*ACT_W  packed codes; feature i occupies bits [i*ACT_W +: ACT_W].
- cfg_we  in  1  threshold write strobe.
- cfg_feat  in  clog2(NUM_FEATURES)  feature index for the write.
- cfg_sel  in  clog2(2^ACT_W-1)  threshold index for the write.
- cfg_data  in  FEAT_W  signed threshold value.
- err_len  out  1  one-cycle pulse on a vector-length violation.

Behaviour:
- Reset (async assert, sync release):
  - s_ready=1, m_valid=0, m_data=0, err_len=0.
  - All thresholds=0, feature index=0, state=FILL.
  - Reset mid-vector discards the partial assembly and any held output.
- Quantization:
  - code = count of thresholds T[f][k] with signed s_data >= T[f][k].
  - The range is 0..2^ACT_W-1. Ascending order is not required.
  - Computed combinationally on the beat and registered into the assembly slot at acceptance.
- Beat acceptance: a beat is accepted when s_valid && s_ready. The feature index increments on each accepted beat.
- State FILL:
  - Vector completes on an accepted beat with index==NUM_FEATURES-1, or with s_last=1.
  - If s_last arrives at index < NUM_FEATURES-1:
    - Remaining slots are filled with code 0.
    - err_len pulses the next cycle.
    - The vector completes.
  - If index==NUM_FEATURES-1 and s_last=0:
    - The vector completes and err_len pulses.
    - The next beat starts a new vector.
  - On completion:
    - If the output register is empty, or is being drained in the same cycle (m_valid && m_ready), transfer: m_data loads and m_valid=1 on the next cycle. Index returns to 0 and the state stays FILL.
    - Otherwise go to WAIT.
- State WAIT:
  - s_ready=0 and the assembly is held.
  - When the output drains (m_ready && m_valid), the assembly transfers that cycle and the state returns to FILL.
  - s_ready=1 from the following cycle.
- Output handshake:
  - m_data is stable while m_valid && !m_ready.
  - m_valid drops the cycle after acceptance unless a new transfer occurs in the same cycle (back-to-back vectors, no bubble).
- Latency: final beat accepted at cycle t gives m_valid=1 at t+1 when the output register is empty.
- Throughput: one feature per cycle sustained when m_ready=1.
- Config writes:
  - Apply at the clock edge and take effect for beats accepted from the next cycle.
  - A write and a beat to the same feature in the same cycle use the old threshold.
  - Out-of-range cfg_feat is ignored.
- s_ready is registered-state driven; there is no combinational path from m_ready to s_ready.

Decomposition:
- Shared package logicnet_pkg:
  - localparams NUM_LEVELS=2^ACT_W, NUM_THR=NUM_LEVELS-1.
  - Packer state enum {FILL, WAIT}.
  - Function clog2.
- One natural sub-module, logicnet_feat_quant: combinational threshold compare-and-count for one feature against NUM_THR thresholds.
- The threshold register file and FSM stay in the top module.

Test Plan:
- Reset thresholds, stream 16 beats of 0x0000/0xFFFF alternating (s_last on beat 16), m_ready=1 -> m_data=0x33333333, i.e. feature0 code 3 (0 >= 0) and feature1 code 0, m_valid one cycle after beat 16.
- Program feature 0 thresholds {-100,0,100}, send s_data=-101,-100,50,100 as feature 0 of four vectors -> feature-0 codes 0,1,2,3.
- Two back-to-back vectors with m_ready held 0 for 20 cycles -> vector 1 held stable; s_ready=0 after vector 2's last beat; on m_ready=1, vector 2 appears the next cycle with no beat lost.
- s_last on beat 5 -> err_len pulse; m_data slots 5..15 = 0; the next beat is slot 0 of a new vector.
- 16 beats without s_last -> vector emitted with err_len pulse; beat 17 lands in slot 0.
- Assert rst mid-vector (beat 7) and while m_valid=1 -> m_valid=0 immediately; next vector assembles from slot 0 with thresholds back to 0.

Source files
------------

// File: rtl/logicnet_pkg.sv
// Shared definitions for the LogicNet input packer.
// Defaults, packer states and a width helper.
package logicnet_pkg;

  localparam int ACT_W_DEF  = 2;
  localparam int NUM_LEVELS = 1 << ACT_W_DEF;
  localparam int NUM_THR    = NUM_LEVELS - 1;

  typedef enum logic {
    FILL,
    WAIT
  } pack_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/logicnet_feat_quant.sv
// Quantizes one signed feature: code is the number
// of thresholds the feature meets or exceeds.
module logicnet_feat_quant
  import logicnet_pkg::*;
#(
  parameter int FEAT_W = 16,
  parameter int ACT_W  = ACT_W_DEF,
  parameter int NTHR   = NUM_THR
) (
  input  logic [FEAT_W-1:0]      data,
  input  logic [NTHR*FEAT_W-1:0] thr,
  output logic [ACT_W-1:0]       code
);

  // Thresholds need not be sorted; a plain count works either way.
  always_comb begin
    code = '0;
    for (int k = 0; k < NTHR; k++) begin
      if ($signed(data) >= $signed(thr[k*FEAT_W +: FEAT_W]))
        code = code + 1'b1;
    end
  end

endmodule

// File: rtl/logicnet_input_packer.sv
// Quantizes a raw feature stream and packs one code
// per feature into an activation vector for layer0.
module logicnet_input_packer
  import logicnet_pkg::*;
#(
  parameter int NUM_FEATURES = 16,
  parameter int FEAT_W       = 16,
  parameter int ACT_W        = ACT_W_DEF,
  localparam int THR_N = (1 << ACT_W) - 1,
  localparam int FW    = clog2(NUM_FEATURES),
  localparam int SW    = clog2(THR_N),
  localparam int VW    = NUM_FEATURES * ACT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FEAT_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [VW-1:0]     m_data,
  input  logic              cfg_we,
  input  logic [FW-1:0]     cfg_feat,
  input  logic [SW-1:0]     cfg_sel,
  input  logic [FEAT_W-1:0] cfg_data,
  output logic              err_len
);

  logic [THR_N*FEAT_W-1:0] thr [NUM_FEATURES];

  pack_state_e state, state_next;
  logic [FW-1:0] idx, idx_next;
  logic [VW-1:0] asm_q, asm_next;
  logic [VW-1:0] m_data_next;
  logic          m_valid_next;
  logic          err_next;
  logic [ACT_W-1:0] code;
  logic accept, last_idx, done;
  logic out_free, cfg_ok;

  assign cfg_ok = cfg_we
               && (int'(cfg_feat) < NUM_FEATURES)
               && (int'(cfg_sel) < THR_N);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < NUM_FEATURES; f++)
        thr[f] <= '0;
    end else if (cfg_ok) begin
      thr[cfg_feat][int'(cfg_sel)*FEAT_W +: FEAT_W] <= cfg_data;
    end
  end

  logicnet_feat_quant #(
    .FEAT_W (FEAT_W),
    .ACT_W  (ACT_W),
    .NTHR   (THR_N)
  ) u_quant (
    .data (s_data),
    .thr  (thr[idx]),
    .code (code)
  );

  assign s_ready  = (state == FILL);
  assign accept   = s_valid && s_ready;
  assign last_idx = (idx == FW'(NUM_FEATURES - 1));
  assign done     = accept && (last_idx || s_last);
  assign out_free = !m_valid || m_ready;

  always_comb begin
    state_next   = state;
    idx_next     = idx;
    asm_next     = asm_q;
    m_valid_next = m_valid;
    m_data_next  = m_data;
    err_next     = 1'b0;
    if (m_valid && m_ready)
      m_valid_next = 1'b0;
    unique case (state)
      FILL: begin
        if (accept) begin
          // An early s_last zero-fills every slot above the current one.
          for (int i = 0; i < NUM_FEATURES; i++) begin
            if (FW'(i) == idx)
              asm_next[i*ACT_W +: ACT_W] = code;
            else if (s_last && (FW'(i) > idx))
              asm_next[i*ACT_W +: ACT_W] = '0;
          end
          idx_next = idx + 1'b1;
          if (done) begin
            idx_next = '0;
            err_next = (s_last != last_idx);
            if (out_free) begin
              m_data_next  = asm_next;
              m_valid_next = 1'b1;
            end else begin
              state_next = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (m_valid && m_ready) begin
          m_data_next  = asm_q;
          m_valid_next = 1'b1;
          state_next   = FILL;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FILL;
      idx     <= '0;
      asm_q   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      err_len <= 1'b0;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      asm_q   <= asm_next;
      m_valid <= m_valid_next;
      m_data  <= m_data_next;
      err_len <= err_next;
    end
  end

endmodule

// File: tb/tb_logicnet_input_packer.sv
// Directed bench for the LogicNet input packer.
// Vector table plus hand-written multi-cycle sequences.
module tb_logicnet_input_packer;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        cfg_we;
  logic [3:0]  cfg_feat;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_data;
  logic        err_len;

  int checks;
  int errors;

  logicnet_input_packer dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .cfg_we   (cfg_we),
    .cfg_feat (cfg_feat),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .err_len  (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] f0;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic beat(input logic [15:0] d, input logic l);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    n = 0;
    while (!s_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout actual=%0d required=<100", n);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_vec(input logic [15:0] first,
                          input logic [15:0] rest,
                          input int nb,
                          input logic last_on_end);
    for (int i = 0; i < nb; i++)
      beat((i == 0) ? first : rest, last_on_end && (i == nb - 1));
  endtask

  task automatic cfg(input logic [3:0] f,
                     input logic [1:0] s,
                     input logic [15:0] v);
    cfg_we   = 1'b1;
    cfg_feat = f;
    cfg_sel  = s;
    cfg_data = v;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  vec_t tbl [4];
  logic stable;

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    s_last   = 1'b0;
    m_ready  = 1'b0;
    cfg_we   = 1'b0;
    cfg_feat = '0;
    cfg_sel  = '0;
    cfg_data = '0;

    tbl[0] = '{16'hFF9B, 32'hFFFF_FFFC};
    tbl[1] = '{16'hFF9C, 32'hFFFF_FFFD};
    tbl[2] = '{16'h0032, 32'hFFFF_FFFE};
    tbl[3] = '{16'h0064, 32'hFFFF_FFFF};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_err_len", 32'(err_len), 32'd0);

    // Alternating 0 / -1 with zero thresholds.
    m_ready = 1'b1;
    for (int i = 0; i < 15; i++)
      beat((i % 2 == 0) ? 16'h0000 : 16'hFFFF, 1'b0);
    check("alt_no_early_valid", 32'(m_valid), 32'd0);
    beat(16'hFFFF, 1'b1);
    check("alt_m_valid", 32'(m_valid), 32'd1);
    check("alt_m_data", m_data, 32'h3333_3333);
    check("alt_err_len", 32'(err_len), 32'd0);

    // Feature 0 thresholds {-100, 0, 100}.
    cfg(4'd0, 2'd0, 16'hFF9C);
    cfg(4'd0, 2'd1, 16'h0000);
    cfg(4'd0, 2'd2, 16'h0064);
    for (int t = 0; t < 4; t++) begin
      send_vec(tbl[t].f0, 16'h0000, 16, 1'b1);
      check($sformatf("tbl%0d_valid", t), 32'(m_valid), 32'd1);
      check($sformatf("tbl%0d_data", t), m_data, tbl[t].exp);
    end

    // Back-to-back vectors against a stalled consumer.
    @(posedge clk);
    #1;
    check("drain_m_valid", 32'(m_valid), 32'd0);
    m_ready = 1'b0;
    send_vec(16'h0000, 16'h0000, 16, 1'b1);
    check("bb_a_valid", 32'(m_valid), 32'd1);
    check("bb_a_data", m_data, 32'hFFFF_FFFE);
    send_vec(16'hFFFF, 16'hFFFF, 16, 1'b1);
    check("bb_wait_s_ready", 32'(s_ready), 32'd0);
    stable = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (m_data !== 32'hFFFF_FFFE || m_valid !== 1'b1)
        stable = 1'b0;
    end
    check("bb_a_stable", 32'(stable), 32'd1);
    check("bb_wait_hold", 32'(s_ready), 32'd0);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bb_b_valid", 32'(m_valid), 32'd1);
    check("bb_b_data", m_data, 32'h0000_0001);
    check("bb_b_s_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    check("bb_b_drop", 32'(m_valid), 32'd0);

    // Early s_last on beat 5.
    send_vec(16'h0000, 16'h0000, 5, 1'b1);
    check("short_valid", 32'(m_valid), 32'd1);
    check("short_data", m_data, 32'h0000_03FE);
    check("short_err", 32'(err_len), 32'd1);
    @(posedge clk);
    #1;
    check("short_err_pulse", 32'(err_len), 32'd0);
    send_vec(16'h0064, 16'hFFFF, 16, 1'b1);
    check("short_next_data", m_data, 32'h0000_0003);
    check("short_next_err", 32'(err_len), 32'd0);

    // Sixteen beats with no s_last.
    send_vec(16'h0064, 16'hFFFF, 16, 1'b0);
    check("long_valid", 32'(m_valid), 32'd1);
    check("long_data", m_data, 32'h0000_0003);
    check("long_err", 32'(err_len), 32'd1);
    send_vec(16'h0000, 16'hFFFF, 16, 1'b1);
    check("long_next_data", m_data, 32'h0000_0002);
    check("long_next_err", 32'(err_len), 32'd0);

    // Reset with a held output and a partial vector.
    m_ready = 1'b0;
    send_vec(16'h0000, 16'h0000, 7, 1'b0);
    check("prerst_valid", 32'(m_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(m_valid), 32'd0);
    check("midrst_data", m_data, 32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    m_ready = 1'b1;
    send_vec(16'hFFFF, 16'h0000, 16, 1'b1);
    check("postrst_valid", 32'(m_valid), 32'd1);
    check("postrst_data", m_data, 32'hFFFF_FFFC);
    check("postrst_err", 32'(err_len), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
